// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host-side blocks.
//   ps2_tx_state_t : host transmitter FSM states
//   PS2_FRAME_BITS : bits in one PS/2 frame (start, 8 data, parity, stop)
//   odd_parity()   : parity bit that makes the byte plus parity odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT
  } ps2_tx_state_t;

  localparam int PS2_FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizer for one raw PS/2 pin.
//   clk, reset_i : system clock, synchronous active-high reset
//   pin_i        : raw asynchronous pin level
//   level_o      : synchronized (optionally filtered) level
//   fall_o       : one-cycle pulse on a high-to-low transition of level_o
//                  (tied low when IS_CLOCK = 0)
// Build option: PS2_TX_FILTER_EN adds an 8-sample deglitch filter on the
// clock-role instance (IS_CLOCK = 1). Without it no filter logic exists.
// Both synchronizer flops reset high because idle PS/2 lines float high.
module ps2_line_sync #(
  parameter bit IS_CLOCK = 1'b1
) (
  input  logic clk,
  input  logic reset_i,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic sync_1;
  logic sync_2;
  logic level_d;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= pin_i;
      sync_2 <= sync_1;
    end
  end

`ifdef PS2_TX_FILTER_EN
  if (IS_CLOCK) begin : g_filter
    logic       filt;
    logic [2:0] run_cnt;

    // The filtered level flips only after 8 consecutive samples that
    // disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
      if (reset_i) begin
        filt    <= 1'b1;
        run_cnt <= '0;
      end else if (sync_2 == filt) begin
        run_cnt <= '0;
      end else if (run_cnt == 3'd7) begin
        filt    <= sync_2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 3'd1;
      end
    end

    assign level_o = filt;
  end else begin : g_no_filter
    assign level_o = sync_2;
  end
`else
  assign level_o = sync_2;
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      level_d <= 1'b1;
    end else begin
      level_d <= level_o;
    end
  end

  assign fall_o = IS_CLOCK & level_d & ~level_o;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the device
// over the open-drain clock/data lines and checks the device ACK bit.
//   clk, reset_i   : system clock, synchronous active-high reset
//   data_i,valid_i : command byte; accepted when valid_i && ready_o
//   ready_o        : high only while idle
//   done_o         : one-cycle pulse, byte sent and ACKed
//   err_o          : one-cycle pulse, timeout or NACK
//   ps2_clk_i      : raw PS/2 clock pin
//   ps2_data_i     : raw PS/2 data pin
//   ps2_clk_oe_o   : 1 pulls the clock line low
//   ps2_data_oe_o  : 1 pulls the data line low
// Build option: PS2_TX_FILTER_EN deglitches the synchronized clock line
// (adds 8 cycles of edge latency).
// Handshake: valid_i/ready_o follow valid/ready semantics; a byte is taken
// on the cycle both are high, and valid_i is ignored while ready_o is low
// (nothing is queued).
// All outputs are registered; the always_comb block computes their next
// values together with the next state.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int FREQ_HZ    = 2_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15_000
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int INH_CYC = FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int TO_CYC  = FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int MAX_CYC = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INH_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);
  // Falls that shift out data, parity and stop; the last one ends SHIFT.
  localparam logic [3:0]    LAST_FALL = 4'(PS2_FRAME_BITS - 2);

  ps2_tx_state_t state, state_nxt;

  // Bits still to drive after the start bit: {stop, parity, byte}, LSB first.
  logic [PS2_FRAME_BITS-2:0] frame_q, frame_nxt;
  logic [3:0]                fall_cnt, fall_cnt_nxt;
  logic [CW-1:0]             tmr, tmr_nxt;

  logic ready_nxt, done_nxt, err_nxt, clk_oe_nxt, data_oe_nxt;

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;

  ps2_line_sync #(.IS_CLOCK(1'b1)) u_clk_sync (
    .clk     (clk),
    .reset_i (reset_i),
    .pin_i   (ps2_clk_i),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_line_sync #(.IS_CLOCK(1'b0)) u_data_sync (
    .clk     (clk),
    .reset_i (reset_i),
    .pin_i   (ps2_data_i),
    .level_o (data_lvl),
    .fall_o  (data_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state         <= IDLE;
      frame_q       <= '0;
      fall_cnt      <= '0;
      tmr           <= '0;
      ready_o       <= 1'b1;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      ps2_clk_oe_o  <= 1'b0;
      ps2_data_oe_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_q       <= frame_nxt;
      fall_cnt      <= fall_cnt_nxt;
      tmr           <= tmr_nxt;
      ready_o       <= ready_nxt;
      done_o        <= done_nxt;
      err_o         <= err_nxt;
      ps2_clk_oe_o  <= clk_oe_nxt;
      ps2_data_oe_o <= data_oe_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    frame_nxt    = frame_q;
    fall_cnt_nxt = fall_cnt;
    tmr_nxt      = tmr;
    ready_nxt    = ready_o;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    clk_oe_nxt   = ps2_clk_oe_o;
    data_oe_nxt  = ps2_data_oe_o;

    unique case (state)
      IDLE: begin
        ready_nxt   = 1'b1;
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        if (valid_i && ready_o) begin
          frame_nxt  = {1'b1, odd_parity(data_i), data_i};
          tmr_nxt    = '0;
          ready_nxt  = 1'b0;
          clk_oe_nxt = 1'b1;
          state_nxt  = INHIBIT;
        end
      end

      // Clock held low; clock falls seen here are our own and ignored.
      INHIBIT: begin
        clk_oe_nxt = 1'b1;
        tmr_nxt    = tmr + CW'(1);
        if (tmr == INH_LAST) begin
          data_oe_nxt = 1'b1;
          state_nxt   = START;
        end
      end

      // One cycle with both lines low, then hand the clock to the device.
      START: begin
        clk_oe_nxt   = 1'b0;
        tmr_nxt      = '0;
        fall_cnt_nxt = '0;
        state_nxt    = SHIFT;
      end

      SHIFT: begin
        if (clk_fall) begin
          data_oe_nxt  = ~frame_q[0];
          frame_nxt    = {1'b1, frame_q[PS2_FRAME_BITS-2:1]};
          fall_cnt_nxt = fall_cnt + 4'd1;
          if (fall_cnt == LAST_FALL) begin
            state_nxt = ACK;
          end
        end
      end

      ACK: begin
        if (clk_fall) begin
          if (!data_lvl) begin
            state_nxt = WAIT;
          end else begin
            err_nxt   = 1'b1;
            ready_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      WAIT: begin
        if (clk_lvl && data_lvl) begin
          done_nxt  = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // The timeout runs from clock release and overrides any other outcome,
    // so done and err can never pulse together.
    if (state == SHIFT || state == ACK || state == WAIT) begin
      tmr_nxt = tmr + CW'(1);
      if (tmr == TO_LAST) begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b1;
        ready_nxt   = 1'b1;
        state_nxt   = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: open-drain line model, a PS/2 device model
// with a 40-cycle clock (20 low / 20 high), and a frame scoreboard.
module tb_ps2_host_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o, done_o, err_o;
  logic       ps2_clk_oe_o, ps2_data_oe_o;
  logic       dev_clk_low, dev_data_low;
  wire        ps2_clk_i  = ~(ps2_clk_oe_o  | dev_clk_low);
  wire        ps2_data_i = ~(ps2_data_oe_o | dev_data_low);

  ps2_host_tx dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .ps2_clk_i     (ps2_clk_i),
    .ps2_data_i    (ps2_data_i),
    .ps2_clk_oe_o  (ps2_clk_oe_o),
    .ps2_data_oe_o (ps2_data_oe_o)
  );

  // ---------------- monitor ----------------
  int cyc_no      = 0;
  int oe_run      = 0;
  int oe_high_len = 0;
  int oe_fall_cyc = 0;
  int err_cyc     = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;
  int both_cnt    = 0;
  logic oe_prev   = 1'b0;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  always @(negedge clk) begin
    oe_run  <= ps2_clk_oe_o ? oe_run + 1 : 0;
    oe_prev <= ps2_clk_oe_o;
    if (!ps2_clk_oe_o && oe_prev) begin
      oe_high_len <= oe_run;
      oe_fall_cyc <= cyc_no;
    end
    if (done_o) done_cnt <= done_cnt + 1;
    if (err_o) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc_no;
    end
    if (done_o && err_o) both_cnt <= both_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wire order of a frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    while (!ready_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("ready_before_send", 32'(ready_o), 32'd1);
    data_i  = b;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    exp_q.push_back(frame_of(b));
  endtask

  // Device: waits for the host to release the clock, then generates falls.
  // The line is sampled at the end of each high phase, just before each fall.
  // With n_falls < 11 it stops after that fall, leaving the clock held low.
  task automatic dev_frame(input int n_falls, input bit ack_ok, input bit glitch,
                           output logic [10:0] obs);
    int g;
    obs = '1;
    g = 0;
    while (!ps2_clk_oe_o && g < 1000) begin
      @(negedge clk);
      g++;
    end
    g = 0;
    while (ps2_clk_oe_o && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("host_released_clk", 32'(ps2_clk_oe_o), 32'd0);
    cyc($urandom_range(4, 40));
    for (int k = 0; k < n_falls && k < 11; k++) begin
      obs[k] = ps2_data_i;
      if (k == 10 && ack_ok) begin
        dev_data_low = 1'b1;
        cyc(2);
      end
      dev_clk_low = 1'b1;
      if (k == n_falls - 1 && n_falls < 11) return;
      cyc(20);
      dev_clk_low = 1'b0;
      cyc(20);
      if (glitch && k == 3) begin
        dev_clk_low = 1'b1;
        cyc(3);
        dev_clk_low = 1'b0;
        cyc(20);
      end
    end
    dev_data_low = 1'b0;
  endtask

  // Full transfer of one byte with ACK, checking frame and outcome.
  task automatic run_ok(input logic [7:0] b, input string tag, input bit glitch);
    logic [10:0] obs;
    logic [10:0] exp;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b);
    dev_frame(11, 1'b1, glitch, obs);
    cyc(10);
    exp = exp_q.pop_front();
    chk({tag, "_frame"}, 32'(obs), 32'(exp));
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] obs;
    logic [10:0] exp;
    int d0, e0, g;
    logic [7:0] rb;

    reset_i      = 1'b1;
    data_i       = '0;
    valid_i      = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    cyc(3);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_oe", 32'({ps2_clk_oe_o, ps2_data_oe_o}), 32'd0);
    reset_i = 1'b0;
    cyc(3);

    // 1: 0xED, inhibit length plus full frame
    run_ok(8'hED, "ed", 1'b0);
    chk("ed_inhibit_len", 32'(oe_high_len), 32'd201);

    // 2: parity 0 and parity 1 cases
    run_ok(8'h01, "x01", 1'b0);
    run_ok(8'hFF, "xff", 1'b0);

    // 3: device never clocks
    e0 = err_cnt;
    d0 = done_cnt;
    send_byte(8'h5A);
    void'(exp_q.pop_front());
    g = 0;
    while (!err_o && g < 31000) begin
      @(negedge clk);
      g++;
    end
    chk("to_err_seen", 32'(err_o), 32'd1);
    chk("to_oe_released", 32'({ps2_clk_oe_o, ps2_data_oe_o}), 32'd0);
    chk("to_ready", 32'(ready_o), 32'd1);
    cyc(3);
    chk("to_latency", 32'(err_cyc - oe_fall_cyc), 32'd30000);
    chk("to_err_once", 32'(err_cnt - e0), 32'd1);
    chk("to_no_done", 32'(done_cnt - d0), 32'd0);

    // 4: NACK at the ACK clock
    e0 = err_cnt;
    d0 = done_cnt;
    send_byte(8'h3C);
    dev_frame(11, 1'b0, 1'b0, obs);
    cyc(10);
    exp = exp_q.pop_front();
    chk("nack_frame", 32'(obs), 32'(exp));
    chk("nack_err_once", 32'(err_cnt - e0), 32'd1);
    chk("nack_no_done", 32'(done_cnt - d0), 32'd0);
    chk("nack_ready", 32'(ready_o), 32'd1);

    // 5: reset after the 4th fall
    d0 = done_cnt;
    send_byte(8'h96);
    void'(exp_q.pop_front());
    dev_frame(4, 1'b1, 1'b0, obs);
    cyc(6);
    reset_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_oe", 32'({ps2_clk_oe_o, ps2_data_oe_o}), 32'd0);
    chk("rst_mid_ready", 32'(ready_o), 32'd1);
    reset_i     = 1'b0;
    dev_clk_low = 1'b0;
    cyc(5);
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    run_ok(8'hF4, "f4", 1'b0);

    // 6: valid held with 0xAA during the 0xED transfer
    d0 = done_cnt;
    send_byte(8'hED);
    data_i  = 8'hAA;
    valid_i = 1'b1;
    dev_frame(11, 1'b1, 1'b0, obs);
    exp = exp_q.pop_front();
    chk("hold_frame_ed", 32'(obs), 32'(exp));
    g = 0;
    while (!done_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("hold_done_seen", 32'(done_o), 32'd1);
    chk("hold_ready_at_done", 32'(ready_o), 32'd1);
    @(negedge clk);
    chk("hold_aa_accepted", 32'({ready_o, ps2_clk_oe_o}), 32'b01);
    valid_i = 1'b0;
    exp_q.push_back(frame_of(8'hAA));
    dev_frame(11, 1'b1, 1'b0, obs);
    cyc(10);
    exp = exp_q.pop_front();
    chk("hold_frame_aa", 32'(obs), 32'(exp));
    chk("hold_done_count", 32'(done_cnt - d0), 32'd2);

`ifdef PS2_TX_FILTER_EN
    run_ok(8'hC3, "glitch", 1'b1);
`endif

    // random bytes
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      run_ok(rb, "rand", 1'b0);
    end

    chk("never_done_and_err", 32'(both_cnt), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
